// File: rtl/isa_vga_target_pkg.sv
// rtl/isa_vga_target_pkg.sv - shared types and constants for the ISA-side VGA target
package isa_vga_target_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ACTIVE,
        HOLD
    } state_e;

    // Bit positions inside the one-hot command vector (a set bit = strobe low)
    localparam int NCMD     = 4;
    localparam int CMD_IOR  = 0;
    localparam int CMD_IOW  = 1;
    localparam int CMD_MEMR = 2;
    localparam int CMD_MEMW = 3;

    localparam logic INDEX_PORT = 1'b0;
    localparam logic DATA_PORT  = 1'b1;

    function automatic logic is_single(input logic [NCMD-1:0] c);
        return (c != '0) && ((c & (c - NCMD'(1))) == '0);
    endfunction

endpackage

// File: rtl/isa_vga_target_if.sv
// rtl/isa_vga_target_if.sv - ISA bus signals between the bridge (master) and the VGA target (slave)
interface isa_vga_target_if;

    logic        BALE;
    logic        SA0;
    logic        SA12;
    logic        IOR;
    logic        IOW;
    logic        MEMR;
    logic        MEMW;
    logic [15:0] DG_IN;
    logic [15:0] DG_OUT;
    logic        DG_OE;
    logic        WAIT;
    logic        err;

    modport master (
        output BALE, SA0, SA12, IOR, IOW, MEMR, MEMW, DG_IN,
        input  DG_OUT, DG_OE, WAIT, err
    );

    modport slave (
        input  BALE, SA0, SA12, IOR, IOW, MEMR, MEMW, DG_IN,
        output DG_OUT, DG_OE, WAIT, err
    );

endinterface

// File: rtl/isa_vga_target_strobe_sync.sv
// rtl/isa_vga_target_strobe_sync.sv - N-bit two-flop synchronizer resetting to the idle-high level
module strobe_sync #(
    parameter int N = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] meta_q;
    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/isa_vga_target.sv
// rtl/isa_vga_target.sv - ISA bus target: index/data register bank in IO space, auto-increment buffer in memory space
module isa_vga_target
    import isa_vga_target_pkg::*;
#(
    parameter int NREGS     = 16,
    parameter int MEM_DEPTH = 64,
    parameter int MEM_WAIT  = 4
) (
    input logic              mclk,
    input logic              reset,
    isa_vga_target_if.slave  bus
);

    localparam int         PW        = $clog2(MEM_DEPTH);
    localparam int         RW        = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

    logic [4:0]      sync;
    logic [NCMD-1:0] cmd;
    logic            bale_s;

    strobe_sync #(.N(5)) u_sync (
        .clk_i   (mclk),
        .reset_i (reset),
        .d_i     ({bus.BALE, bus.MEMW, bus.MEMR, bus.IOW, bus.IOR}),
        .q_o     (sync)
    );

    assign cmd    = ~sync[3:0];
    assign bale_s = sync[4];

    state_e          state_q;
    logic [NCMD-1:0] cmd_q;
    logic [3:0]      cnt_q;
    logic            bale_q;
    logic            sa0_q;
    logic            sa12_q;
    logic [7:0]      index_q;
    logic [15:0]     regs_q [NREGS];
    logic [PW-1:0]   mem_ptr_q;
    logic [15:0]     buf_q [MEM_DEPTH];
    logic [15:0]     dg_out_q;
    logic            dg_oe_q;
    logic            wait_q;
    logic            err_q;

    logic [RW-1:0]   reg_sel;
    logic [NCMD-1:0] commit_cmd;
    logic            commit;
    logic            held;
    logic [15:0]     reg_wdata;
    logic [15:0]     buf_wdata;
    logic [15:0]     rd_data;

    // IO cycles commit straight out of IDLE; memory cycles commit on the last wait cycle
    always_comb begin
        reg_sel    = RW'({24'd0, index_q} % NREGS);
        held       = |(cmd & cmd_q);
        commit_cmd = '0;
        if (state_q == IDLE && is_single(cmd) && (cmd[CMD_IOR] || cmd[CMD_IOW])) begin
            commit_cmd = cmd;
        end else if (state_q == DELAY && held && cnt_q == 4'd1) begin
            commit_cmd = cmd_q;
        end
        commit    = |commit_cmd;
        reg_wdata = sa0_q ? {bus.DG_IN[15:8], regs_q[reg_sel][7:0]} : bus.DG_IN;
        buf_wdata = sa0_q ? {bus.DG_IN[15:8], buf_q[mem_ptr_q][7:0]} : bus.DG_IN;
        if (commit_cmd[CMD_MEMR]) begin
            rd_data = buf_q[mem_ptr_q];
        end else if (sa12_q == INDEX_PORT) begin
            rd_data = {8'h00, index_q};
        end else begin
            rd_data = regs_q[reg_sel];
        end
    end

    // The buffer keeps its contents across reset
    always_ff @(posedge mclk) begin
        if (!reset && commit_cmd[CMD_MEMW]) begin
            buf_q[mem_ptr_q] <= buf_wdata;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            cnt_q     <= '0;
            bale_q    <= 1'b1;
            sa0_q     <= 1'b0;
            sa12_q    <= 1'b0;
            index_q   <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            mem_ptr_q <= '0;
            dg_out_q  <= '0;
            dg_oe_q   <= 1'b0;
            wait_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            bale_q <= bale_s;
            if (bale_q && !bale_s) begin
                sa0_q  <= bus.SA0;
                sa12_q <= bus.SA12;
            end
            err_q <= 1'b0;

            if (commit) begin
                if (commit_cmd[CMD_IOR] || commit_cmd[CMD_MEMR]) begin
                    dg_out_q <= rd_data;
                    dg_oe_q  <= 1'b1;
                end
                if (commit_cmd[CMD_IOW]) begin
                    if (sa12_q == INDEX_PORT) begin
                        index_q <= bus.DG_IN[7:0];
                    end else begin
                        regs_q[reg_sel] <= reg_wdata;
                        if (reg_sel == '0) mem_ptr_q <= bus.DG_IN[PW-1:0];
                    end
                end
                if (commit_cmd[CMD_MEMR] || commit_cmd[CMD_MEMW]) begin
                    mem_ptr_q <= mem_ptr_q + PW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (commit) begin
                        cmd_q   <= cmd;
                        state_q <= ACTIVE;
                    end else if (is_single(cmd)) begin
                        cmd_q   <= cmd;
                        cnt_q   <= WAIT_LOAD;
                        wait_q  <= 1'b0;
                        state_q <= DELAY;
                    end else if (cmd != '0) begin
                        err_q   <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                DELAY: begin
                    if (!held) begin
                        wait_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (commit) begin
                        wait_q  <= 1'b1;
                        state_q <= ACTIVE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ACTIVE: begin
                    if (!held) begin
                        dg_oe_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (cmd == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.DG_OUT = dg_out_q;
    assign bus.DG_OE  = dg_oe_q;
    assign bus.WAIT   = wait_q;
    assign bus.err    = err_q;

endmodule
